// File: rtl/pipe_stage_regs.sv
// Pipeline register bank for the 5-stage MIPS core: PC, IF/ID, ID/EX, EX/MEM, MEM/WB,
// plus per-stage PC/valid tracking and free-running debug counters.
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC = 32'h00003000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic [31:0]      NPC,
  input  logic [31:0]      InstrF,
  input  logic             movWriteE,
  input  logic             bWriteE,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      InstrE,
  output logic [31:0]      PCE,
  output logic [31:0]      InstrM,
  output logic [31:0]      PCM,
  output logic             movWriteM,
  output logic             bWriteM,
  output logic [31:0]      InstrW,
  output logic [31:0]      PCW,
  output logic             movWriteW,
  output logic             bWriteW,
  output logic             ValidW,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] RetireCnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic validD;
  logic validE;
  logic validM;
  logic validW;

  assign ValidW = validW;

  // PC and IF/ID: frozen while the hazard unit stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF    <= RESET_PC;
      InstrD <= '0;
      PCD    <= '0;
      validD <= 1'b0;
    end else if (!Stall) begin
      PCF    <= NPC;
      InstrD <= InstrF;
      PCD    <= PCF;
      validD <= 1'b1;
    end
  end

  // ID/EX: a stall injects a bubble (sll $0 nop) instead of holding
  always_ff @(posedge clk) begin
    if (reset || Stall) begin
      InstrE <= '0;
      PCE    <= '0;
      validE <= 1'b0;
    end else begin
      InstrE <= InstrD;
      PCE    <= PCD;
      validE <= validD;
    end
  end

  // EX/MEM: always advances; write flags are sampled only here
  always_ff @(posedge clk) begin
    if (reset) begin
      InstrM    <= '0;
      PCM       <= '0;
      validM    <= 1'b0;
      movWriteM <= 1'b0;
      bWriteM   <= 1'b0;
    end else begin
      InstrM    <= InstrE;
      PCM       <= PCE;
      validM    <= validE;
      movWriteM <= movWriteE;
      bWriteM   <= bWriteE;
    end
  end

  // MEM/WB
  always_ff @(posedge clk) begin
    if (reset) begin
      InstrW    <= '0;
      PCW       <= '0;
      validW    <= 1'b0;
      movWriteW <= 1'b0;
      bWriteW   <= 1'b0;
    end else begin
      InstrW    <= InstrM;
      PCW       <= PCM;
      validW    <= validM;
      movWriteW <= movWriteM;
      bWriteW   <= bWriteM;
    end
  end

  // Debug counters; retire counts the instruction leaving WB on this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      CycleCnt  <= '0;
      StallCnt  <= '0;
      RetireCnt <= '0;
    end else begin
      CycleCnt <= CycleCnt + CntOne;
      if (Stall)  StallCnt  <= StallCnt + CntOne;
      if (validW) RetireCnt <= RetireCnt + CntOne;
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Self-checking bench for pipe_stage_regs: directed scenarios plus randomized traffic
// against an instruction-slot model; a second instance uses 4-bit counters to exercise wrap.
module tb_pipe_stage_regs;

  localparam logic [31:0] RST_PC = 32'h00003000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic [31:0] NPC = '0;
  logic [31:0] InstrF = '0;
  logic        movWriteE = 1'b0;
  logic        bWriteE = 1'b0;

  logic [31:0] PCF, InstrD, PCD, InstrE, PCE, InstrM, PCM, InstrW, PCW;
  logic        movWriteM, bWriteM, movWriteW, bWriteW, ValidW;
  logic [31:0] CycleCnt, StallCnt, RetireCnt;

  logic [31:0] pcf2, instrD2, pcD2, instrE2, pcE2, instrM2, pcM2, instrW2, pcW2;
  logic        movM2, bM2, movW2, bW2, validW2;
  logic [3:0]  cyc2, stl2, ret2;

  int nChecks = 0;
  int nPass = 0;

  always #5 clk = ~clk;

  pipe_stage_regs #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .NPC(NPC), .InstrF(InstrF),
    .movWriteE(movWriteE), .bWriteE(bWriteE),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .InstrE(InstrE), .PCE(PCE),
    .InstrM(InstrM), .PCM(PCM), .movWriteM(movWriteM), .bWriteM(bWriteM),
    .InstrW(InstrW), .PCW(PCW), .movWriteW(movWriteW), .bWriteW(bWriteW),
    .ValidW(ValidW), .CycleCnt(CycleCnt), .StallCnt(StallCnt), .RetireCnt(RetireCnt)
  );

  pipe_stage_regs #(.RESET_PC(RST_PC), .CNT_W(4)) dutSmall (
    .clk(clk), .reset(reset), .Stall(Stall), .NPC(NPC), .InstrF(InstrF),
    .movWriteE(movWriteE), .bWriteE(bWriteE),
    .PCF(pcf2), .InstrD(instrD2), .PCD(pcD2), .InstrE(instrE2), .PCE(pcE2),
    .InstrM(instrM2), .PCM(pcM2), .movWriteM(movM2), .bWriteM(bM2),
    .InstrW(instrW2), .PCW(pcW2), .movWriteW(movW2), .bWriteW(bW2),
    .ValidW(validW2), .CycleCnt(cyc2), .StallCnt(stl2), .RetireCnt(ret2)
  );

  // Model: one record per instruction slot, slots 0..3 = D, E, M, W
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        mov;
    logic        b;
  } rec_t;

  localparam rec_t BUBBLE = '{instr: 32'h0, pc: 32'h0, valid: 1'b0, mov: 1'b0, b: 1'b0};

  rec_t        pipe [4];
  logic [31:0] mPCF;
  logic [31:0] mCyc, mStl, mRet;

  task automatic model_edge();
    rec_t nxt [4];
    if (reset) begin
      mPCF = RST_PC;
      for (int i = 0; i < 4; i++) pipe[i] = BUBBLE;
      mCyc = 0; mStl = 0; mRet = 0;
    end else begin
      mCyc = mCyc + 1;
      if (Stall) mStl = mStl + 1;
      if (pipe[3].valid) mRet = mRet + 1;
      nxt[3] = pipe[2];
      nxt[2] = pipe[1];
      nxt[2].mov = movWriteE;
      nxt[2].b = bWriteE;
      if (Stall) begin
        nxt[1] = BUBBLE;
        nxt[0] = pipe[0];
      end else begin
        nxt[1] = pipe[0];
        nxt[1].mov = 1'b0;
        nxt[1].b = 1'b0;
        nxt[0] = '{instr: InstrF, pc: mPCF, valid: 1'b1, mov: 1'b0, b: 1'b0};
        mPCF = NPC;
      end
      for (int i = 0; i < 4; i++) pipe[i] = nxt[i];
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [31:0] npc,
                      input logic [31:0] instr, input logic mv, input logic bw);
    @(negedge clk);
    reset = r; Stall = s; NPC = npc; InstrF = instr; movWriteE = mv; bWriteE = bw;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input logic [31:0] instr);
    step(1'b0, 1'b0, mPCF + 32'd4, instr, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 32'h0, 32'hdead_beef, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 32'hdead_beef, 1'b1, 1'b1);
    nChecks++;
    if (PCF !== RST_PC) $display("FAIL reset_pcf got=%h want=%h", PCF, RST_PC);
    else nPass++;
    nChecks++;
    if ({InstrD, InstrE, InstrM, InstrW} !== 128'h0)
      $display("FAIL reset_instr got=%h %h %h %h want=0", InstrD, InstrE, InstrM, InstrW);
    else nPass++;
    nChecks++;
    if ({PCD, PCE, PCM, PCW} !== 128'h0)
      $display("FAIL reset_pc got=%h %h %h %h want=0", PCD, PCE, PCM, PCW);
    else nPass++;
    nChecks++;
    if ({ValidW, movWriteM, bWriteM, movWriteW, bWriteW} !== 5'b0)
      $display("FAIL reset_flags got=%b want=00000",
               {ValidW, movWriteM, bWriteM, movWriteW, bWriteW});
    else nPass++;
    nChecks++;
    if ({CycleCnt, StallCnt, RetireCnt} !== 96'h0)
      $display("FAIL reset_cnt got=%0d %0d %0d want=0 0 0", CycleCnt, StallCnt, RetireCnt);
    else nPass++;
  endtask

  task automatic test_fill();
    logic [31:0] seq [4];
    seq[0] = 32'h0000_000a; seq[1] = 32'h0000_000b;
    seq[2] = 32'h0000_000c; seq[3] = 32'h0000_000d;
    for (int k = 0; k < 4; k++) begin
      run(seq[k]);
      nChecks++;
      if (PCF !== RST_PC + 32'(4 * (k + 1)))
        $display("FAIL fill_pcf%0d got=%h want=%h", k, PCF, RST_PC + 32'(4 * (k + 1)));
      else nPass++;
    end
    nChecks++;
    if ({InstrW, PCW, ValidW} !== {32'h0000_000a, RST_PC, 1'b1})
      $display("FAIL fill_w got=%h/%h/%b want=0000000a/%h/1", InstrW, PCW, ValidW, RST_PC);
    else nPass++;
    nChecks++;
    if ({InstrM, InstrE, InstrD} !== {32'h0000_000b, 32'h0000_000c, 32'h0000_000d})
      $display("FAIL fill_mid got=%h %h %h want=b c d", InstrM, InstrE, InstrD);
    else nPass++;
    nChecks++;
    if (RetireCnt !== 32'd0) $display("FAIL fill_ret0 got=%0d want=0", RetireCnt);
    else nPass++;
    run(32'h0000_000e);
    nChecks++;
    if ({RetireCnt, CycleCnt, ValidW} !== {32'd1, 32'd5, 1'b1})
      $display("FAIL fill_ret1 got=%0d/%0d/%b want=1/5/1", RetireCnt, CycleCnt, ValidW);
    else nPass++;
  endtask

  task automatic test_single_stall();
    logic [31:0] heldInstr, heldPc, heldPcf;
    heldInstr = pipe[0].instr; heldPc = pipe[0].pc; heldPcf = mPCF;
    step(1'b0, 1'b1, 32'hffff_fff0, 32'h1234_5678, 1'b0, 1'b0);
    nChecks++;
    if ({PCF, InstrD, PCD} !== {heldPcf, heldInstr, heldPc})
      $display("FAIL stall1_hold got=%h/%h/%h want=%h/%h/%h", PCF, InstrD, PCD,
               heldPcf, heldInstr, heldPc);
    else nPass++;
    nChecks++;
    if ({InstrE, PCE} !== 64'h0) $display("FAIL stall1_bubble got=%h/%h want=0/0", InstrE, PCE);
    else nPass++;
    nChecks++;
    if (StallCnt !== 32'd1) $display("FAIL stall1_cnt got=%0d want=1", StallCnt);
    else nPass++;
    run(32'h0000_0101);
    nChecks++;
    if (InstrE !== heldInstr) $display("FAIL stall1_resume got=%h want=%h", InstrE, heldInstr);
    else nPass++;
    run(32'h0000_0102);
    nChecks++;
    if ({ValidW, InstrW} !== {1'b0, 32'h0})
      $display("FAIL stall1_wbubble got=%b/%h want=0/0", ValidW, InstrW);
    else nPass++;
    run(32'h0000_0103);
    nChecks++;
    if (ValidW !== 1'b1) $display("FAIL stall1_wvalid got=%b want=1", ValidW);
    else nPass++;
  endtask

  task automatic test_multi_stall();
    logic [31:0] heldInstr, heldPcf, stl0;
    heldInstr = pipe[0].instr; heldPcf = mPCF; stl0 = mStl;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
      nChecks++;
      if ({PCF, InstrD, InstrE, PCE} !== {heldPcf, heldInstr, 32'h0, 32'h0})
        $display("FAIL stall3_hold%0d got=%h/%h/%h/%h want=%h/%h/0/0", k, PCF, InstrD,
                 InstrE, PCE, heldPcf, heldInstr);
      else nPass++;
    end
    nChecks++;
    if (StallCnt !== stl0 + 32'd3) $display("FAIL stall3_cnt got=%0d want=%0d", StallCnt, stl0 + 3);
    else nPass++;
    nChecks++;
    if (ValidW !== 1'b0) $display("FAIL stall3_w0 got=%b want=0", ValidW);
    else nPass++;
    for (int k = 1; k < 4; k++) begin
      run(32'h0000_0200 + 32'(k));
      nChecks++;
      if (ValidW !== (k == 3)) $display("FAIL stall3_w%0d got=%b want=%b", k, ValidW, k == 3);
      else nPass++;
    end
    nChecks++;
    if ({CycleCnt, RetireCnt} !== {mCyc, mRet})
      $display("FAIL stall3_lag got=%0d/%0d want=%0d/%0d", CycleCnt, RetireCnt, mCyc, mRet);
    else nPass++;
  endtask

  task automatic test_flags();
    step(1'b0, 1'b0, mPCF + 32'd4, 32'h0000_0301, 1'b1, 1'b0);
    nChecks++;
    if ({movWriteM, bWriteM} !== 2'b10) $display("FAIL mov_m got=%b%b want=10", movWriteM, bWriteM);
    else nPass++;
    step(1'b0, 1'b0, mPCF + 32'd4, 32'h0000_0302, 1'b0, 1'b1);
    nChecks++;
    if ({movWriteM, bWriteM, movWriteW, bWriteW} !== 4'b0110)
      $display("FAIL mov_w got=%b%b%b%b want=0110", movWriteM, bWriteM, movWriteW, bWriteW);
    else nPass++;
    step(1'b0, 1'b0, mPCF + 32'd4, 32'h0000_0303, 1'b0, 1'b0);
    nChecks++;
    if ({movWriteM, bWriteM, movWriteW, bWriteW} !== 4'b0001)
      $display("FAIL mov_clr got=%b%b%b%b want=0001", movWriteM, bWriteM, movWriteW, bWriteW);
    else nPass++;
    run(32'h0000_0304);
    nChecks++;
    if ({movWriteW, bWriteW} !== 2'b00) $display("FAIL b_clr got=%b%b want=00", movWriteW, bWriteW);
    else nPass++;
  endtask

  task automatic test_reset_midstall();
    for (int k = 0; k < 4; k++) run(32'h0000_0400 + 32'(k));
    step(1'b1, 1'b1, 32'h0000_9990, 32'h0000_0499, 1'b1, 1'b1);
    nChecks++;
    if ({PCF, InstrD, InstrE, InstrM, InstrW} !== {RST_PC, 128'h0})
      $display("FAIL rststall_regs got=%h %h %h %h %h want=%h 0 0 0 0", PCF, InstrD,
               InstrE, InstrM, InstrW, RST_PC);
    else nPass++;
    nChecks++;
    if ({ValidW, CycleCnt, StallCnt, RetireCnt} !== 97'h0)
      $display("FAIL rststall_cnt got=%b %0d %0d %0d want=0 0 0 0", ValidW, CycleCnt,
               StallCnt, RetireCnt);
    else nPass++;
    run(32'h0000_0500);
    nChecks++;
    if ({InstrD, PCD, PCF} !== {32'h0000_0500, RST_PC, RST_PC + 32'd4})
      $display("FAIL rststall_fetch got=%h/%h/%h want=00000500/%h/%h", InstrD, PCD, PCF,
               RST_PC, RST_PC + 32'd4);
    else nPass++;
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      run(32'h0000_0600 + 32'(k));
      nChecks++;
      if ({cyc2, pcf2, instrW2} !== {4'(k % 16), mPCF, pipe[3].instr})
        $display("FAIL wrap%0d got=%0d/%h/%h want=%0d/%h/%h", k, cyc2, pcf2, instrW2,
                 k % 16, mPCF, pipe[3].instr);
      else nPass++;
    end
    nChecks++;
    if (ret2 !== mRet[3:0]) $display("FAIL wrap_ret got=%0d want=%0d", ret2, mRet[3:0]);
    else nPass++;
  endtask

  task automatic test_random();
    logic        r, s;
    logic [31:0] npc;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      npc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hffff_fffc) : mPCF + 32'd4;
      step(r, s, npc, $urandom, 1'($urandom), 1'($urandom));
      nChecks++;
      if ({PCF, InstrD, PCD, InstrE, PCE} !==
          {mPCF, pipe[0].instr, pipe[0].pc, pipe[1].instr, pipe[1].pc})
        $display("FAIL rand_fde%0d got=%h %h %h %h %h want=%h %h %h %h %h", n, PCF, InstrD,
                 PCD, InstrE, PCE, mPCF, pipe[0].instr, pipe[0].pc, pipe[1].instr, pipe[1].pc);
      else nPass++;
      nChecks++;
      if ({InstrM, PCM, movWriteM, bWriteM, InstrW, PCW, movWriteW, bWriteW, ValidW} !==
          {pipe[2].instr, pipe[2].pc, pipe[2].mov, pipe[2].b,
           pipe[3].instr, pipe[3].pc, pipe[3].mov, pipe[3].b, pipe[3].valid})
        $display("FAIL rand_mw%0d got=%h %h %b%b %h %h %b%b%b want=%h %h %b%b %h %h %b%b%b", n,
                 InstrM, PCM, movWriteM, bWriteM, InstrW, PCW, movWriteW, bWriteW, ValidW,
                 pipe[2].instr, pipe[2].pc, pipe[2].mov, pipe[2].b, pipe[3].instr,
                 pipe[3].pc, pipe[3].mov, pipe[3].b, pipe[3].valid);
      else nPass++;
      nChecks++;
      if ({CycleCnt, StallCnt, RetireCnt, cyc2, stl2, ret2} !==
          {mCyc, mStl, mRet, mCyc[3:0], mStl[3:0], mRet[3:0]})
        $display("FAIL rand_cnt%0d got=%0d %0d %0d %0d %0d %0d want=%0d %0d %0d %0d %0d %0d", n,
                 CycleCnt, StallCnt, RetireCnt, cyc2, stl2, ret2,
                 mCyc, mStl, mRet, mCyc[3:0], mStl[3:0], mRet[3:0]);
      else nPass++;
    end
  endtask

  initial begin
    mPCF = RST_PC;
    for (int i = 0; i < 4; i++) pipe[i] = BUBBLE;
    mCyc = 0; mStl = 0; mRet = 0;
    test_reset();
    test_fill();
    test_single_stall();
    test_multi_stall();
    test_flags();
    test_reset_midstall();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
Pipeline register bank for the 5-stage MIPS core: PC register, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Produces InstrD/E/M/W and movWrite*/bWrite* for the hazard unit, and consumes its Stall to freeze PC and IF/ID and to bubble ID/EX.
- Also carries per-stage PC and valid bits, and keeps cycle, stall and retire counters for debug.
- Sits between the fetch/next-PC logic and the datapath stages.

Parameters:
RESET_PC, 32'h00003000, PCF value after reset.
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  clock; all registers update on its rising edge
reset  input  1  synchronous, active-high reset
Stall  input  1  from hazard unit: hold PC and IF/ID, bubble ID/EX
NPC  input  32  next-PC from branch/jump logic
InstrF  input  32  instruction fetched at PCF
movWriteE  input  1  EX-stage conditional-move write enable (movz/movn outcome)
bWriteE  input  1  EX-stage branch-link write enable
PCF  output  32  fetch PC
InstrD, PCD  output  32 each  ID-stage instruction / PC
InstrE, PCE  output  32 each  EX-stage instruction / PC
InstrM, PCM  output  32 each  MEM-stage instruction / PC
movWriteM, bWriteM  output  1 each  MEM-stage write flags
InstrW, PCW  output  32 each  WB-stage instruction / PC
movWriteW, bWriteW  output  1 each  WB-stage write flags
ValidW  output  1  WB holds a real instruction, not a bubble
CycleCnt  output  CNT_W  cycles since reset
StallCnt  output  CNT_W  cycles with Stall=1
RetireCnt  output  CNT_W  instructions retired from WB

Behaviour:
- Reset (reset=1 at an edge):
  - PCF=RESET_PC.
  - All Instr*=0 (sll $0 nop). All PC* except PCF =0.
  - All valid bits, movWrite*/bWrite* and all counters =0.
  - Reset has priority over Stall and over every other input.
- Internal valid bits: validD, validE, validM, validW; ValidW = validW.
- Normal edge (Stall=0):
  - PCF<=NPC.
  - InstrD<=InstrF, PCD<=PCF, validD<=1.
  - InstrE/PCE/validE <= D values.
  - InstrM/PCM/validM <= E values; movWriteM<=movWriteE, bWriteM<=bWriteE.
  - InstrW/PCW/validW/movWriteW/bWriteW <= M values.
- Stall edge (Stall=1):
  - PCF and all D-stage registers hold.
  - E stage loads a bubble: InstrE=0, PCE=0, validE=0.
  - M and W advance exactly as in a normal edge; Stall never holds M or W.
- Latency: an instruction in F at edge n appears in D after n, E after n+1, M after n+2, W after n+3, provided no stall. Each stall cycle adds one cycle for D and every younger instruction.
- Multi-cycle stall: D holds for every consecutive cycle with Stall=1, and one bubble enters E per stall cycle. InstrF is ignored while stalled.
- Flags are sampled only from EX. A bubble in E has movWriteE=bWriteE=0 by datapath contract; no extra masking is done here.
- Counters, on every non-reset edge:
  - CycleCnt+=1.
  - StallCnt+=1 if Stall=1.
  - RetireCnt+=1 if validW=1, using the pre-edge value, i.e. the instruction leaving WB.
  - All counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-stall or mid-flight: every stage is discarded at that edge. The first fetch after reset is at RESET_PC.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset, then Stall=0 with NPC=PCF+4 and InstrF=A,B,C,D on successive cycles:
   - PCF sequence 3000, 3004, 3008, ...
   - InstrW=A four edges after A was presented; ValidW=1 from then on.
   - RetireCnt=1 one edge after InstrW=A.
2. Stall=1 for one cycle with InstrD=X:
   - PCF and InstrD=X held.
   - Next InstrE=0 and ValidE bubble reaches W three edges later, with ValidW=0 for that cycle.
   - StallCnt=1.
3. Stall=1 for three consecutive cycles:
   - D held for 3 edges; three consecutive bubbles in E.
   - StallCnt=3.
   - RetireCnt lags CycleCnt by 3 + pipeline-fill cycles.
4. movWriteE=1, bWriteE=0 at edge n:
   - movWriteM=1 after n, movWriteW=1 after n+1, then clears when followed by movWriteE=0.
   - bWrite* stay 0.
5. reset=1 asserted while Stall=1 and all stages valid:
   - Next edge: PCF=3000, all Instr*=0, ValidW=0, counters=0.
   - Stall on the same edge has no effect.
6. Preload the counters near wrap (or CNT_W=4 build), run 20 cycles:
   - CycleCnt wraps 15→0 without disturbing the pipeline registers.
